// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencing controller.
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAIT  = 3'd1,
      ISSUE = 3'd2,
      HALT  = 3'd3
   } fetch_state_t;

   localparam logic [31:0] PC_RESET   = 32'h0000_0000;
   localparam int          WAIT_CNT_W = 3;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-control bus: run/step/halt control, pipeline hazard/redirect inputs and PC/IF-stage strobes.
interface fetch_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
);
   logic                  run_en;
   logic                  step_req;
   logic                  resume;
   logic                  stall_d;
   logic                  branch_taken;
   logic [DATA_WIDTH-1:0] branch_target;
   logic                  ebreak_d;
   logic                  pc_trigger;
   logic                  pc_src;
   logic [DATA_WIDTH-1:0] pc_target;
   logic                  if_valid;
   logic                  flush_d;
   logic                  halted;
   logic [2:0]            state;
   logic [CNT_WIDTH-1:0]  fetch_cnt;

   modport master (
      input  run_en, step_req, resume, stall_d, branch_taken, branch_target, ebreak_d,
      output pc_trigger, pc_src, pc_target, if_valid, flush_d, halted, state, fetch_cnt
   );

   modport slave (
      output run_en, step_req, resume, stall_d, branch_taken, branch_target, ebreak_d,
      input  pc_trigger, pc_src, pc_target, if_valid, flush_d, halted, state, fetch_cnt
   );
endinterface

// File: rtl/fetch_wait_cnt.sv
// Loadable down-counter timing instruction-memory wait states; holds at zero.
module fetch_wait_cnt
   import fetch_pkg::*;
#(
   parameter int W = WAIT_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (dec && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - W'(1);
      end
   end

   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// PC/instruction-fetch sequencer: memory wait states, run/step/halt control and
// redirect/stall arbitration driving the PC register and IF/decode strobes.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_LAT    = 1,
   parameter int CNT_WIDTH  = 32
) (
   input logic          clk,
   input logic          rst,
   fetch_ctrl_if.master bus
);

   localparam int                    RELOAD_I = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;
   localparam logic [WAIT_CNT_W-1:0] RELOAD   = RELOAD_I[WAIT_CNT_W-1:0];
   // With zero memory latency every refetch goes straight to ISSUE.
   localparam fetch_state_t          REFETCH  = (MEM_LAT == 0) ? ISSUE : WAIT;

   fetch_state_t          state_reg, state_next;
   logic                  step_reg, step_next;
   logic [CNT_WIDTH-1:0]  cnt_reg;
   logic [DATA_WIDTH-1:0] target_w;
   logic                  cnt_inc, wait_load, wait_dec, wait_zero;
   logic                  trig_c, src_c, valid_c, flush_c, halted_c;

   fetch_wait_cnt #(.W(WAIT_CNT_W)) u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (wait_load),
      .load_val (RELOAD),
      .dec      (wait_dec),
      .zero     (wait_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         step_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         step_reg  <= step_next;
         if (cnt_inc) begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      step_next  = step_reg;
      trig_c     = 1'b0;
      src_c      = 1'b0;
      valid_c    = 1'b0;
      flush_c    = 1'b0;
      halted_c   = 1'b0;
      cnt_inc    = 1'b0;
      wait_load  = 1'b0;
      wait_dec   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.run_en || bus.step_req) begin
               state_next = REFETCH;
               wait_load  = 1'b1;
               if (bus.step_req) begin
                  step_next = 1'b1;
               end
            end
         end
         WAIT: begin
            if (bus.branch_taken) begin
               trig_c     = 1'b1;
               src_c      = 1'b1;
               flush_c    = 1'b1;
               wait_load  = 1'b1;
               state_next = REFETCH;
            end else if (wait_zero) begin
               state_next = ISSUE;
            end else begin
               wait_dec = 1'b1;
            end
         end
         ISSUE: begin
            if (bus.branch_taken) begin
               trig_c     = 1'b1;
               src_c      = 1'b1;
               flush_c    = 1'b1;
               wait_load  = 1'b1;
               state_next = REFETCH;
            end else if (bus.ebreak_d) begin
               // The ebreak itself counts as issued; the PC stays on it.
               valid_c    = 1'b1;
               cnt_inc    = 1'b1;
               state_next = HALT;
            end else if (bus.stall_d) begin
               valid_c = 1'b1;
            end else begin
               valid_c = 1'b1;
               trig_c  = 1'b1;
               cnt_inc = 1'b1;
               if (step_reg || !bus.run_en) begin
                  step_next  = 1'b0;
                  state_next = IDLE;
               end else begin
                  wait_load  = 1'b1;
                  state_next = REFETCH;
               end
            end
         end
         HALT: begin
            halted_c = 1'b1;
            if (bus.resume) begin
               wait_load  = 1'b1;
               state_next = REFETCH;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign target_w       = bus.branch_target;
   assign bus.pc_target  = target_w;
   assign bus.pc_trigger = trig_c;
   assign bus.pc_src     = src_c;
   assign bus.if_valid   = valid_c;
   assign bus.flush_d    = flush_c;
   assign bus.halted     = halted_c;
   assign bus.state      = state_reg;
   assign bus.fetch_cnt  = cnt_reg;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the PC/instruction-fetch stage. Drives the PC register's advance enable (trigger), the next-PC select (PCSrc) and the redirect target. Inserts wait states for instruction-memory latency and handles run/halt/single-step control. Arbitrates between hazard stalls, branch redirects and halt, and emits the IF-stage valid and decode-flush strobes.

Parameters:
DATA_WIDTH, 32, PC/instruction width
MEM_LAT, 1, instruction-memory wait cycles after a PC change (0..7)
CNT_WIDTH, 32, width of the fetched-instruction counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
run_en  input  1  level; 1 = free-run fetch
step_req  input  1  single-cycle pulse; fetch exactly one instruction from IDLE
resume  input  1  single-cycle pulse; leave HALT
stall_d  input  1  hazard-unit stall request
branch_taken  input  1  redirect request from EX
branch_target  input  DATA_WIDTH  redirect address
ebreak_d  input  1  halt instruction decoded
pc_trigger  output  1  PC register load enable
pc_src  output  1  0 = PC+4, 1 = target
pc_target  output  DATA_WIDTH  redirect address to the PC mux
if_valid  output  1  IF instruction valid this cycle
flush_d  output  1  kill the instruction in decode
halted  output  1  FSM in HALT
state  output  3  FSM state encoding (debug)
fetch_cnt  output  CNT_WIDTH  number of instructions issued

Behaviour:
- Reset (async): state=IDLE, wait counter=0, fetch_cnt=0, step flag=0. All 1-bit outputs 0.
- States: IDLE=0, WAIT=1, ISSUE=2, HALT=3. Other encodings go to IDLE.
- Priority within a cycle: rst > branch_taken > ebreak_d > stall_d > run_en/step.
- IDLE:
  - Outputs are quiescent.
  - run_en=1 or step_req=1 -> WAIT, loading the counter with MEM_LAT-1; if MEM_LAT=0 -> ISSUE directly.
  - step_req sets the step flag. Branch, ebreak and stall are ignored in IDLE.
- WAIT:
  - The counter decrements each cycle; counter==0 -> ISSUE.
  - if_valid=0 and pc_trigger=0.
  - branch_taken: pc_src=1, pc_trigger=1, flush_d=1, counter reloads with MEM_LAT-1, stay in WAIT (or go ISSUE if MEM_LAT=0).
- ISSUE:
  - if_valid=1 unless branch_taken.
  - branch_taken:
    - pc_trigger=1, pc_src=1, flush_d=1, if_valid=0.
    - fetch_cnt is not incremented.
    - Next state is WAIT (counter reload), or stay in ISSUE if MEM_LAT=0.
  - ebreak_d: pc_trigger=0, fetch_cnt +1, -> HALT.
  - stall_d:
    - pc_trigger=0; stay in ISSUE with if_valid=1 held.
    - fetch_cnt is not incremented.
    - Repeats for every stalled cycle.
  - Otherwise:
    - pc_trigger=1, pc_src=0, fetch_cnt +1.
    - If the step flag is set or run_en=0: clear the step flag, -> IDLE.
    - Else -> WAIT with counter reload (stay in ISSUE if MEM_LAT=0).
- HALT:
  - halted=1; all other strobes 0.
  - resume -> WAIT (or ISSUE if MEM_LAT=0), with the PC unchanged.
  - branch_taken in HALT is ignored.
- pc_target = branch_target combinationally, always.
- pc_src is valid only when pc_trigger=1; otherwise it is 0.
- fetch_cnt wraps modulo 2^CNT_WIDTH without saturation.
- run_en falling mid-WAIT: the pending fetch completes one ISSUE, then -> IDLE.
- Reset asserted mid-operation returns to IDLE in the same cycle, with no trigger pulse.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum (IDLE/WAIT/ISSUE/HALT, 3-bit).
  - PC_RESET constant 0.
  - WAIT_CNT_W = 3.
- One sub-module, fetch_wait_cnt: a loadable down-counter with load/decrement/zero flag.
- The FSM and output decode stay in fetch_ctrl.

Test Plan:
- MEM_LAT=1, reset, run_en=1 for 10 cycles -> pc_trigger pulses every 2nd cycle; if_valid coincides with each pulse; fetch_cnt=5 at cycle 10.
- MEM_LAT=0, run_en=1, stall_d high for 3 cycles during ISSUE -> pc_trigger=0 for 3 cycles with if_valid held at 1; fetch_cnt frozen; resumes with +1 per cycle.
- ISSUE with branch_taken=1 and stall_d=1 together, branch_target=0x40 -> pc_trigger=1, pc_src=1, pc_target=0x40, flush_d=1, if_valid=0; fetch_cnt unchanged.
- run_en=0, step_req pulse, MEM_LAT=2 -> exactly one pc_trigger, 3 cycles after the pulse; fetch_cnt=1; back in IDLE (state=0).
- ebreak_d in ISSUE -> halted=1 next cycle, no trigger; resume pulse -> WAIT, then ISSUE; halted=0.
- Async rst asserted mid-WAIT -> all outputs 0 immediately; state=0; fetch_cnt=0; no trigger after deassert until run_en.
